// File: rtl/task_12_pkg.sv
// Shared types and constants for the task_12 answer packer slice.
package task_12_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    REQUEST = 2'd1,
    SEND    = 2'd2
  } state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned PKT_SIZE_W = 12;

endpackage

// File: rtl/task_12_answer_packer_if.sv
// Result-word input and answer-packet output bundle of the task_12 answer packer.
// The slave modport is the packer side; master is the serializer/task-manager side.
interface task_12_answer_packer_if
  import task_12_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32
) ();

  logic                  i_data_valid;
  logic [WORD_WIDTH-1:0] i_data;
  logic                  i_input_last;
  logic                  i_tmanager_ready;
  logic                  o_tanswer_ready;
  logic [WORD_WIDTH-1:0] o_tdata;
  logic                  o_tanswer_data_last;
  logic [PKT_SIZE_W-1:0] o_packet_size_in_bytes;
  logic                  o_overflow;

  modport master (
    output i_data_valid, i_data, i_input_last, i_tmanager_ready,
    input  o_tanswer_ready, o_tdata, o_tanswer_data_last,
           o_packet_size_in_bytes, o_overflow
  );

  modport slave (
    input  i_data_valid, i_data, i_input_last, i_tmanager_ready,
    output o_tanswer_ready, o_tdata, o_tanswer_data_last,
           o_packet_size_in_bytes, o_overflow
  );

endinterface

// File: rtl/task_12_answer_fifo.sv
// First-word-fall-through word buffer for the answer packer.
// The parent only pushes when not full (or popping) and only pops when non-empty.
module task_12_answer_fifo #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_push,
  input  logic [WORD_WIDTH-1:0]   i_data,
  input  logic                    i_pop,
  output logic [WORD_WIDTH-1:0]   o_head,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WORD_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and fill-count bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head and status views.
  always_comb begin
    o_head  = r_mem[r_rd_ptr];
    o_count = r_count;
    o_full  = (r_count == CW'(DEPTH));
  end

endmodule

// File: rtl/task_12_answer_packer.sv
// task_12 answer packer: buffers result words and frames them into answer
// packets (ready request, ready-gated stream, last flag, byte count).
// Optional build macro TASK_12_ANSWER_CHECKSUM_EN appends an XOR checksum beat.
module task_12_answer_packer
  import task_12_pkg::*;
#(
  parameter int unsigned WORD_WIDTH       = 32,
  parameter int unsigned DEPTH            = 8,
  parameter int unsigned WORDS_PER_PACKET = 3
) (
  input logic                     i_clk,
  input logic                     i_rst,
  task_12_answer_packer_if.slave  bus
);

  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam int unsigned BCW = $clog2(WORDS_PER_PACKET + 2);
`ifdef TASK_12_ANSWER_CHECKSUM_EN
  localparam int unsigned EXTRA_BEATS = 1;
`else
  localparam int unsigned EXTRA_BEATS = 0;
`endif
  localparam logic [CW:0]           WPP_E      = (CW+1)'(WORDS_PER_PACKET);
  localparam logic [CW-1:0]         WPP_C      = CW'(WORDS_PER_PACKET);
  localparam logic [PKT_SIZE_W-1:0] EXTRA_SIZE = PKT_SIZE_W'(EXTRA_BEATS * WORD_BYTES);

  state_t                r_state;
  logic [BCW-1:0]        r_beats_left;
  logic                  r_flush;
  logic [PKT_SIZE_W-1:0] r_size;
  logic                  r_overflow;

  logic [WORD_WIDTH-1:0] w_head;
  logic [CW-1:0]         w_count;
  logic                  w_full;
  logic                  w_ready, w_beat, w_last_beat, w_data_beat;
  logic                  w_pop, w_push;
  logic [CW:0]           w_eff_fill;
  logic                  w_flush_req, w_start_full, w_start_flush, w_start;
  logic [CW-1:0]         w_pkt_words;
  logic [PKT_SIZE_W-1:0] w_size;

  task_12_answer_fifo #(
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_data  (bus.i_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full)
  );

  // Handshake, buffer control and packet-start decision.
  // A flush counts the word written in the same cycle; a full-packet start
  // uses the registered count so the ready latency stays one cycle.
  always_comb begin
    w_ready       = (r_state != COLLECT);
    w_beat        = w_ready && bus.i_tmanager_ready;
    w_last_beat   = (r_beats_left == BCW'(1));
`ifdef TASK_12_ANSWER_CHECKSUM_EN
    w_data_beat   = !w_last_beat;
`else
    w_data_beat   = 1'b1;
`endif
    w_pop         = w_beat && w_data_beat;
    w_push        = bus.i_data_valid && (!w_full || w_pop);
    w_eff_fill    = {1'b0, w_count} + (CW+1)'(w_push);
    w_flush_req   = bus.i_input_last || r_flush;
    w_start_full  = (w_count >= WPP_C);
    w_start_flush = w_flush_req && (w_eff_fill != '0);
    w_start       = (r_state == COLLECT) && (w_start_full || w_start_flush);
    if (w_start_full || (w_eff_fill >= WPP_E)) begin
      w_pkt_words = WPP_C;
    end else begin
      w_pkt_words = CW'(w_eff_fill);
    end
    w_size = PKT_SIZE_W'(w_pkt_words) * PKT_SIZE_W'(WORD_BYTES) + EXTRA_SIZE;
  end

  // Packet FSM, beat counter, size latch and pending-flush flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= COLLECT;
      r_beats_left <= '0;
      r_flush      <= 1'b0;
      r_size       <= '0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_start) begin
            r_state      <= REQUEST;
            r_beats_left <= BCW'(w_pkt_words) + BCW'(EXTRA_BEATS);
            r_size       <= w_size;
            // keep the flush pending while words beyond this packet remain
            r_flush      <= w_flush_req && (w_eff_fill > {1'b0, w_pkt_words});
          end
        end
        REQUEST, SEND: begin
          if (bus.i_input_last) r_flush <= 1'b1;
          if (w_beat) begin
            r_beats_left <= r_beats_left - BCW'(1);
            r_state      <= w_last_beat ? COLLECT : SEND;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  // Sticky overflow on any discarded write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overflow <= 1'b0;
    end else if (bus.i_data_valid && !w_push) begin
      r_overflow <= 1'b1;
    end
  end

`ifdef TASK_12_ANSWER_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] r_csum;

  // Running XOR of the data words of the current packet.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_start) begin
      r_csum <= '0;
    end else if (w_pop) begin
      r_csum <= r_csum ^ w_head;
    end
  end
`endif

  // Output drive; data is forced to zero while no packet is offered.
  always_comb begin
    bus.o_tanswer_ready        = w_ready;
    bus.o_tdata                = '0;
    if (w_ready) begin
`ifdef TASK_12_ANSWER_CHECKSUM_EN
      bus.o_tdata              = w_last_beat ? r_csum : w_head;
`else
      bus.o_tdata              = w_head;
`endif
    end
    bus.o_tanswer_data_last    = w_ready && w_last_beat;
    bus.o_packet_size_in_bytes = r_size;
    bus.o_overflow             = r_overflow;
  end

endmodule

// File: doc/task_12_answer_packer.md
# task_12_answer_packer

Downstream stage of the task_12 serializer. Accepts 32-bit result words one per valid cycle, buffers them, and frames them into answer packets for the task manager: answer-ready request, ready-gated word stream, last-word flag and byte count. It decouples the robot-arm result timing from the task manager's readiness and flushes a short packet when the input stream ends.

## Interface
- WORD_WIDTH, 32, width of buffered and emitted words.
- DEPTH, 8, buffer capacity in words; power of two, at least WORDS_PER_PACKET + 1.
- WORDS_PER_PACKET, 3, words per full answer packet (x, y, z).

- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_data_valid  in  1  i_data carries a word this cycle.
- i_data  in  WORD_WIDTH  result word from serializer.
- i_input_last  in  1  one-cycle pulse: input packet ended; flush a partial packet.
- i_tmanager_ready  in  1  task manager accepts a word this cycle.
- o_tanswer_ready  out  1  packet available; a beat transfers when this and i_tmanager_ready are both high.
- o_tdata  out  WORD_WIDTH  current word, head of buffer.
- o_tanswer_data_last  out  1  o_tdata is the final word of the packet.
- o_packet_size_in_bytes  out  12  byte length of the current packet.
- o_overflow  out  1  sticky: a word was dropped because the buffer was full.

## Operation
- State machine: COLLECT, REQUEST, SEND.
- COLLECT: o_tanswer_ready=0. Go to REQUEST when fill count reaches WORDS_PER_PACKET, or when i_input_last is seen with fill count > 0. i_input_last with an empty buffer is ignored.
- On entering REQUEST, latch pkt_words = min(fill, WORDS_PER_PACKET). Set o_packet_size_in_bytes = pkt_words*4 (+4 with checksum).
- REQUEST/SEND: o_tanswer_ready=1 and o_tdata = buffer head. On each beat (ready && i_tmanager_ready), pop one word and decrement the beat counter.
- o_tanswer_data_last=1 when the beat counter shows one word remaining.
- After the last beat, return to COLLECT. If the fill count already meets the entry condition, go directly to REQUEST, with o_tanswer_ready low for exactly one cycle between packets.
- Writes continue in every state. A write and a pop in the same cycle leave the fill count unchanged.
- Write when full (fill = DEPTH with no pop that cycle): the word is discarded and o_overflow is set.
- A pending i_input_last that arrives during REQUEST/SEND is remembered (flush flag) and applied in COLLECT.

## Timing
- Reset values: o_tanswer_ready=0, o_tdata=0, o_tanswer_data_last=0, o_packet_size_in_bytes=0, o_overflow=0. Buffer pointers, counters, flush flag and state also clear; state = COLLECT.
- Reset mid-packet aborts the packet, emits no last, and drops buffered words.
- Latency: the word that completes a packet is written at edge N; o_tanswer_ready and the first o_tdata are valid after edge N+1.
- o_tdata, o_tanswer_data_last and o_packet_size_in_bytes hold stable while o_tanswer_ready=1 and i_tmanager_ready=0. Stalls are unbounded.
- Throughput: one beat per cycle while i_tmanager_ready stays high.
- Pointers wrap modulo DEPTH. The fill counter is log2(DEPTH)+1 bits wide.

## Configuration
- TASK_12_ANSWER_CHECKSUM_EN defined:
  - After the last data word, one extra beat carries the XOR of all packet data words.
  - o_tanswer_data_last asserts on the checksum beat only.
  - The size includes 4 extra bytes.
- Undefined: no checksum beat and no checksum logic.

## Structure
- task_12_pkg:
  - state enum (COLLECT, REQUEST, SEND)
  - WORD_BYTES = 4
  - the packet-size width of 12
- Sub-module task_12_answer_fifo: first-word-fall-through FIFO with push, pop, head, count and full. The packer FSM, beat counter, checksum and overflow logic sit in the parent.

## Test plan
- Three words 0x11, 0x22, 0x33 with i_tmanager_ready held high -> o_tanswer_ready rises one cycle after the third write; three beats 0x11/0x22/0x33 are emitted, last on 0x33, size = 12.
- Two words 0xA, 0xB, then an i_input_last pulse -> short packet of 0xA, 0xB, last on 0xB, size = 8.
- Full packet with i_tmanager_ready low for 5 cycles, then high -> o_tdata holds 0x11 with last = 0 during the stall, then the stream completes correctly.
- Nine words written back-to-back with ready low (DEPTH=8) -> o_overflow = 1; the first eight words are delivered in order across packets 3, 3 and 2 (the last packet after i_input_last).
- Reset asserted during the second beat -> next cycle all outputs are 0; the following 3 words form a clean packet of size 12.
- Checksum build, words 0x1, 0x2, 0x4 -> four beats, the fourth is 0x7 with last, size = 16.
